// File: rtl/cache_pkg.sv
// Shared constants, address field ranges and FSM state type for the cache refill controller.
package cache_pkg;
  localparam int ADDR_W     = 15;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int CNT_W      = 16;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int OFF_W      = 2;

  localparam int TAG_HI    = 14;
  localparam int TAG_LO    = 12;
  localparam int INDEX_HI  = 11;
  localparam int INDEX_LO  = 2;
  localparam int OFFSET_HI = 1;
  localparam int OFFSET_LO = 0;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESPOND} state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/cache_line_buffer.sv
// Refill line buffer: one register per word, written beat by beat, cleared at refill start.
module cache_line_buffer
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              write,
  input  logic [OFF_W-1:0]  index,
  input  logic [WORD_W-1:0] data,
  input  logic [OFF_W-1:0]  select,
  output logic [LINE_W-1:0] line,
  output logic [WORD_W-1:0] word
);
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (clear) begin
          word_reg <= '0;
        end else if (write && (index == OFF_W'(gi))) begin
          word_reg <= data;
        end
      end

      assign line[gi*WORD_W +: WORD_W] = word_reg;
    end
  endgenerate

  assign word = line[select*WORD_W +: WORD_W];
endmodule

// File: rtl/cache_refill_controller.sv
// Direct-mapped cache read controller: lookup, 4-beat in-order refill, single-cycle line write, respond.
module cache_refill_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic              cpu_ready,
  output logic [WORD_W-1:0] cpu_data,
  output logic              stall,
  output logic [ADDR_W-1:0] cache_address,
  output logic              cache_read_enable,
  input  logic              cache_hit,
  input  logic [WORD_W-1:0] cache_data,
  output logic              cache_write_enable,
  output logic [LINE_W-1:0] cache_line,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_valid,
  input  logic [WORD_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [OFF_W-1:0]  idx_reg;
  logic              buf_clear, buf_write;
  logic [WORD_W-1:0] buf_word;

  cache_line_buffer u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .clear  (buf_clear),
    .write  (buf_write),
    .index  (idx_reg),
    .data   (mem_data),
    .select (addr_reg[OFFSET_HI:OFFSET_LO]),
    .line   (cache_line),
    .word   (buf_word)
  );

  always_comb begin
    state_next         = state_reg;
    cache_address      = '0;
    cache_read_enable  = 1'b0;
    cache_write_enable = 1'b0;
    mem_read           = 1'b0;
    mem_address        = '0;
    cpu_ready          = 1'b0;
    buf_clear          = 1'b0;
    buf_write          = 1'b0;
    case (state_reg)
      IDLE: begin
        cache_address = cpu_address;
        if (cpu_read) state_next = LOOKUP;
      end
      LOOKUP: begin
        cache_address     = addr_reg;
        cache_read_enable = 1'b1;
        if (cache_hit) begin
          state_next = RESPOND;
        end else begin
          buf_clear  = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        mem_read    = 1'b1;
        mem_address = {addr_reg[ADDR_W-1:INDEX_LO], idx_reg};
        if (mem_valid) begin
          buf_write = 1'b1;
          if (idx_reg == OFF_W'(LINE_WORDS - 1)) state_next = WRITE;
        end
      end
      WRITE: begin
        cache_write_enable = 1'b1;
        cache_address      = addr_reg;
        state_next         = RESPOND;
      end
      RESPOND: begin
        cpu_ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // IDLE passes cpu_address straight through; hold it at zero while reset is active.
    if (rst) cache_address = '0;
  end

  assign stall = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      idx_reg    <= '0;
      cpu_data   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (cpu_read) addr_reg <= cpu_address;
        LOOKUP: begin
          if (cache_hit) begin
            cpu_data  <= cache_data;
            hit_count <= sat_inc(hit_count);
          end else begin
            miss_count <= sat_inc(miss_count);
            idx_reg    <= '0;
          end
        end
        FILL: if (mem_valid) idx_reg <= idx_reg + 1'b1;
        // The requested word comes from the freshly assembled buffer, not a cache re-read.
        WRITE: cpu_data <= buf_word;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_refill_controller.sv
// Randomized scoreboard bench: behavioural cache/memory environment plus a tag-table reference model.
module tb_cache_refill_controller;
  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_read;
  logic [14:0]  cpu_address;
  logic         cpu_ready;
  logic [31:0]  cpu_data;
  logic         stall;
  logic [14:0]  cache_address;
  logic         cache_read_enable;
  logic         cache_hit;
  logic [31:0]  cache_data;
  logic         cache_write_enable;
  logic [127:0] cache_line;
  logic         mem_read;
  logic [14:0]  mem_address;
  logic         mem_valid;
  logic [31:0]  mem_data;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  cache_refill_controller dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .stall(stall),
    .cache_address(cache_address), .cache_read_enable(cache_read_enable),
    .cache_hit(cache_hit), .cache_data(cache_data),
    .cache_write_enable(cache_write_enable), .cache_line(cache_line),
    .mem_read(mem_read), .mem_address(mem_address), .mem_valid(mem_valid),
    .mem_data(mem_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- environment: cache array ----------------
  logic         cvalid [1024];
  logic [2:0]   ctag   [1024];
  logic [127:0] cline  [1024];

  always_comb begin
    cache_hit  = cvalid[cache_address[11:2]] && (ctag[cache_address[11:2]] == cache_address[14:12]);
    cache_data = cline[cache_address[11:2]][cache_address[1:0]*32 +: 32];
  end

  always @(posedge clk) begin
    if (!rst && cache_write_enable) begin
      cvalid[cache_address[11:2]] <= 1'b1;
      ctag[cache_address[11:2]]   <= cache_address[14:12];
      cline[cache_address[11:2]]  <= cache_line;
    end
  end

  // ---------------- environment: memory with random wait states ----------------
  int max_wait = 0;
  int wait_cnt = 0;

  always @(negedge clk) begin
    if (mem_read && !rst) begin
      if (wait_cnt == 0) begin
        mem_valid = 1'b1;
        mem_data  = 32'hA000_0000 | 32'(mem_address);
        wait_cnt  = $urandom_range(0, max_wait);
      end else begin
        mem_valid = 1'b0;
        wait_cnt--;
      end
    end else begin
      // stray valids while no beat is requested must be ignored
      mem_valid = 1'($urandom_range(0, 1));
      mem_data  = $urandom;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    bit          hit;
    logic [15:0] hits;
    logic [15:0] misses;
    time         t0;
  } resp_t;

  resp_t        rq[$];
  logic [14:0]  aq[$];
  logic [127:0] lq[$];
  logic         mvalid [1024];
  logic [2:0]   mtag   [1024];
  logic [15:0]  mh = 0, mm = 0;
  logic [31:0]  last_data = 0;
  bit           pending = 0;
  time          cur_t0 = 0;
  int           resp_count = 0;
  int           beats_seen = 0;
  int           fill_cycles = 0;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #2;
    if (rst) begin
      fill_cycles = 0;
    end else begin
      resp_t r;
      int lat;
      chk("stall", 128'(stall), 128'(pending && ($time - 2 > cur_t0)));
      chk("strobe_exclusive",
          128'(int'(cpu_ready) + int'(mem_read) + int'(cache_write_enable) + int'(cache_read_enable) > 1), 128'(0));
      if (mem_read) fill_cycles++;
      if (mem_read && mem_valid) begin
        beats_seen++;
        if (aq.size() == 0) chk("unexpected_beat", 128'(mem_address), 128'h1_0000);
        else chk("mem_address", 128'(mem_address), 128'(aq.pop_front()));
      end
      if (cache_write_enable) begin
        if (lq.size() == 0) chk("unexpected_line_write", 128'(1), 128'(0));
        else chk("cache_line", cache_line, lq.pop_front());
      end
      if (cpu_ready) begin
        if (rq.size() == 0) begin
          chk("unexpected_cpu_ready", 128'(1), 128'(0));
        end else begin
          r   = rq.pop_front();
          lat = int'(($time - 2 - r.t0) / 10);
          chk("cpu_data", 128'(cpu_data), 128'(r.data));
          chk("hit_count", 128'(hit_count), 128'(r.hits));
          chk("miss_count", 128'(miss_count), 128'(r.misses));
          chk(r.hit ? "hit_latency" : "miss_latency", 128'(lat), 128'(r.hit ? 2 : 3 + fill_cycles));
          last_data = r.data;
        end
        pending = 0;
        fill_cycles = 0;
        resp_count++;
      end else begin
        chk("cpu_data_hold", 128'(cpu_data), 128'(last_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic predict_miss(input logic [14:0] a, input int nbeats);
    logic [127:0] ln;
    for (int k = 0; k < 4; k++) begin
      logic [14:0] ba;
      ba = {a[14:2], 2'(k)};
      ln[k*32 +: 32] = 32'hA000_0000 | 32'(ba);
      if (k < nbeats) aq.push_back(ba);
    end
    if (nbeats == 4) lq.push_back(ln);
  endtask

  task automatic do_read(input logic [14:0] a, input bit chaos);
    resp_t r;
    bit    hit;
    int    start;
    @(negedge clk);
    hit = mvalid[a[11:2]] && (mtag[a[11:2]] == a[14:12]);
    if (hit) begin
      mh = sat(mh);
    end else begin
      mm = sat(mm);
      predict_miss(a, 4);
      mvalid[a[11:2]] = 1'b1;
      mtag[a[11:2]]   = a[14:12];
    end
    r.data = 32'hA000_0000 | 32'(a);
    r.hit = hit; r.hits = mh; r.misses = mm; r.t0 = $time;
    rq.push_back(r);
    cpu_read = 1'b1; cpu_address = a;
    cur_t0 = $time; pending = 1; start = resp_count;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (chaos) begin
        cpu_read = 1'($urandom_range(0, 1));
        cpu_address = 15'h7FFF;
      end else begin
        cpu_read = 1'b0;
      end
      #3;
      if (resp_count != start) break;
    end
    cpu_read = 1'b0;
    if (resp_count == start) begin
      chk("response_timeout", 128'(0), 128'(1));
      rq.delete(); aq.delete(); lq.delete(); pending = 0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_cpu_ready"}, 128'(cpu_ready), 128'(0));
    chk({tag, "_cpu_data"}, 128'(cpu_data), 128'(0));
    chk({tag, "_stall"}, 128'(stall), 128'(0));
    chk({tag, "_cache_address"}, 128'(cache_address), 128'(0));
    chk({tag, "_cache_read_enable"}, 128'(cache_read_enable), 128'(0));
    chk({tag, "_cache_write_enable"}, 128'(cache_write_enable), 128'(0));
    chk({tag, "_cache_line"}, cache_line, 128'(0));
    chk({tag, "_mem_read"}, 128'(mem_read), 128'(0));
    chk({tag, "_mem_address"}, 128'(mem_address), 128'(0));
    chk({tag, "_hit_count"}, 128'(hit_count), 128'(0));
    chk({tag, "_miss_count"}, 128'(miss_count), 128'(0));
  endtask

  initial begin
    logic [14:0] a;
    logic        old_v;
    logic [2:0]  old_t;
    int          b0;
    for (int i = 0; i < 1024; i++) begin
      cvalid[i] = 1'b0; ctag[i] = '0; cline[i] = '0;
      mvalid[i] = 1'b0; mtag[i] = '0;
    end
    rst = 1'b1; cpu_read = 1'b0; cpu_address = 15'h1234;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // directed sequence with zero-wait memory
    do_read(15'h0005, 0);
    do_read(15'h0006, 0);
    do_read(15'h1004, 0);
    do_read(15'h0005, 0);
    chk("miss_count_after_directed", 128'(miss_count), 128'(3));
    chk("hit_count_after_directed", 128'(hit_count), 128'(1));

    // random addresses over a few indexes and tags, random memory wait states
    max_wait = 5;
    for (int n = 0; n < 40; n++) begin
      a = {3'($urandom_range(0, 2)), 10'(16 + $urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_read(a, 0);
    end

    // abort a refill with reset after the second accepted beat
    @(negedge clk);
    a = 15'h0008;
    old_v = mvalid[a[11:2]]; old_t = mtag[a[11:2]];
    predict_miss(a, 2);
    cpu_read = 1'b1; cpu_address = a; cur_t0 = $time; pending = 1;
    b0 = beats_seen;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cpu_read = 1'b0;
      #3;
      if (beats_seen - b0 >= 2) break;
    end
    chk("abort_two_beats", 128'(beats_seen - b0 >= 2), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    repeat (2) @(negedge clk);
    rq.delete(); aq.delete(); lq.delete();
    pending = 0; mh = 0; mm = 0; last_data = 0;
    mvalid[a[11:2]] = old_v; mtag[a[11:2]] = old_t;
    rst = 1'b0;
    do_read(15'h0008, 0);

    // CPU misbehaves while stalled: toggling read and a bogus address
    do_read(15'h2030, 1);
    do_read(15'h2031, 1);

    repeat (3) @(negedge clk);
    chk("queues_drained", 128'(rq.size() + aq.size() + lq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
